// File: rtl/fp64_divider_if.sv
// -----------------------------------------------------------------------------
// fp64_divider_if
// Request/response bundle for the binary64 divider.
//   master (requester): drives start, a, b; observes busy, done, quo
//   slave  (divider)  : observes start, a, b; drives busy, done, quo
//   start : request, taken only while busy=0
//   a, b  : dividend / divisor, captured on the accepting edge
//   busy  : operation in flight
//   done  : one-cycle pulse, quo valid from that cycle
//   quo   : quotient, held until the next done
// -----------------------------------------------------------------------------
interface fp64_divider_if;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] quo;

    modport master (output start, a, b, input  busy, done, quo);
    modport slave  (input  start, a, b, output busy, done, quo);
endinterface

// File: rtl/fp64_divider.sv
// -----------------------------------------------------------------------------
// fp64_divider
// Iterative IEEE-754 binary64 divider: restoring division, one quotient bit
// per cycle, truncating rounding, subnormals flushed to zero. Every operand
// class, special cases included, takes the same 55-cycle latency.
//   clk : clock, rising edge
//   rst : synchronous reset, active high; aborts any in-flight operation
//   bus : fp64_divider_if.slave (start/a/b in, busy/done/quo out)
// -----------------------------------------------------------------------------
module fp64_divider (
    input  logic          clk,
    input  logic          rst,
    fp64_divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    // Result class decided at accept time; NORM only uses it to select output.
    typedef enum logic [1:0] {CLS_FIN, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

    typedef struct packed {
        logic               sign;
        logic signed [12:0] exp;   // ea - eb + bias, before normalisation
        cls_t               cls;
    } op_t;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [53:0] rem_q,   rem_d;
    logic [53:0] q_q,     q_d;
    logic [52:0] mb_q,    mb_d;
    op_t         op_q,    op_d;
    logic [63:0] quo_q,   quo_d;
    logic        done_q,  done_d;

    // ---------------- operand decode (used only on the accepting edge) -------
    logic [10:0] ea, eb;
    logic [51:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    cls_t        in_cls;

    always_comb begin
        ea     = bus.a[62:52];
        eb     = bus.b[62:52];
        fa     = bus.a[51:0];
        fb     = bus.b[51:0];
        a_nan  = (ea == 11'h7FF) && (fa != '0);
        b_nan  = (eb == 11'h7FF) && (fb != '0);
        a_inf  = (ea == 11'h7FF) && (fa == '0);
        b_inf  = (eb == 11'h7FF) && (fb == '0);
        a_zero = (ea == 11'h000);   // subnormals count as zero
        b_zero = (eb == 11'h000);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            in_cls = CLS_NAN;
        else if (a_inf || b_zero)
            in_cls = CLS_INF;
        else if (a_zero || b_inf)
            in_cls = CLS_ZERO;
        else
            in_cls = CLS_FIN;
    end

    // ---------------- restoring step -----------------------------------------
    // Invariant: rem < 2*mb, so after a successful subtract the difference is
    // below mb and fits in 53 bits; the modulo-2^53 subtract is exact.
    logic        ge;
    logic [52:0] diff;

    always_comb begin
        ge   = (rem_q >= {1'b0, mb_q});
        diff = ge ? (rem_q[52:0] - mb_q) : rem_q[52:0];
    end

    // ---------------- normalise + pack ---------------------------------------
    logic signed [12:0] exp_n;
    logic [51:0]        frac_n;
    logic [63:0]        norm_res;

    always_comb begin
        exp_n  = q_q[53] ? op_q.exp : (op_q.exp - 13'sd1);
        frac_n = q_q[53] ? q_q[52:1] : q_q[51:0];
        case (op_q.cls)
            CLS_NAN:  norm_res = QNAN;
            CLS_INF:  norm_res = {op_q.sign, 11'h7FF, 52'h0};
            CLS_ZERO: norm_res = {op_q.sign, 63'h0};
            default: begin
                if (exp_n >= 13'sd2047)
                    norm_res = {op_q.sign, 11'h7FF, 52'h0};
                else if (exp_n <= 13'sd0)
                    norm_res = {op_q.sign, 63'h0};
                else
                    norm_res = {op_q.sign, exp_n[10:0], frac_n};
            end
        endcase
    end

    // ---------------- next state ---------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        mb_d    = mb_q;
        op_d    = op_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = DIV;
                    cnt_d       = '0;
                    rem_d       = {2'b01, fa};
                    q_d         = '0;
                    mb_d        = {1'b1, fb};
                    op_d.sign   = bus.a[63] ^ bus.b[63];
                    op_d.exp    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
                    op_d.cls    = in_cls;
                end
            end
            DIV: begin
                rem_d = {diff, 1'b0};
                q_d   = {q_q[52:0], ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd53)
                    state_d = NORM;
            end
            NORM: begin
                state_d = IDLE;
                quo_d   = norm_res;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            mb_q    <= '0;
            op_q    <= '0;
            quo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            mb_q    <= mb_d;
            op_q    <= op_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.quo  = quo_q;

endmodule
